// File: rtl/display_scan_mux.sv
// Multiplexed digit scanner feeding the 5-bit-code to 7-segment decoder.
// It blanks all digits between each pair of lit digits and swaps new codes in only at frame boundaries.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_BLANK| all digits off, code_out already holds the upcoming digit code
// ST_SHOW | digit idx lit (digit_en_n[idx] low), code_out = display[idx]
module display_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int CODE_W     = 5,
    parameter int DWELL      = 1000,
    parameter int BLANK      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic [NUM_DIGITS*CODE_W-1:0] digits_in,
    output logic                         load_ack,
    output logic [CODE_W-1:0]            code_out,
    output logic [NUM_DIGITS-1:0]        digit_en_n,
    output logic                         frame_start
);

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

    state_t                              state, state_nxt;
    logic [CNT_W-1:0]                    cnt, cnt_nxt;
    logic [IDX_W-1:0]                    idx, idx_nxt;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]   display, display_nxt;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]   pending, pending_nxt;
    logic                                pend_flag, pend_flag_nxt;
    logic                                ack_nxt;
    logic [CODE_W-1:0]                   code_nxt;
    logic [NUM_DIGITS-1:0]               en_nxt;
    logic                                fs_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BLANK;
            cnt         <= '0;
            idx         <= '0;
            display     <= '0;
            pending     <= '0;
            pend_flag   <= 1'b0;
            load_ack    <= 1'b0;
            code_out    <= '0;
            digit_en_n  <= '1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            display     <= display_nxt;
            pending     <= pending_nxt;
            pend_flag   <= pend_flag_nxt;
            load_ack    <= ack_nxt;
            code_out    <= code_nxt;
            digit_en_n  <= en_nxt;
            frame_start <= fs_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        idx_nxt       = idx;
        display_nxt   = display;
        pending_nxt   = pending;
        pend_flag_nxt = pend_flag;
        ack_nxt       = 1'b0;
        fs_nxt        = 1'b0;

        case (state)
            ST_BLANK: begin
                if (cnt == CNT_W'(BLANK - 1)) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                    fs_nxt    = (idx == '0);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                if (cnt == CNT_W'(DWELL - 1)) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                        idx_nxt = '0;
                        // Frame boundary: commit uses the pending value from before this cycle's load
                        if (pend_flag) begin
                            display_nxt   = pending;
                            pend_flag_nxt = 1'b0;
                            ack_nxt       = 1'b1;
                        end
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase

        if (load) begin
            pending_nxt   = digits_in;
            pend_flag_nxt = 1'b1;
        end

        // Outputs are registered against the next state so they line up with it
        code_nxt = display_nxt[idx_nxt];
        en_nxt   = (state_nxt == ST_SHOW) ? ~(NUM_DIGITS'(1) << idx_nxt) : '1;
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench for display_scan_mux with 4 digits, DWELL=8, BLANK=2 (40-cycle frame).
// Expected frame contents are queued when loads are driven and popped when a frame is observed.
module tb_display_scan_mux;

    localparam int ND = 4;
    localparam int CW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load = 1'b0;
    logic [ND*CW-1:0]  digits_in = '0;
    logic              load_ack;
    logic [CW-1:0]     code_out;
    logic [ND-1:0]     digit_en_n;
    logic              frame_start;

    int compared   = 0;
    int mismatched = 0;

    logic [ND*CW-1:0] sb[$];

    display_scan_mux #(.NUM_DIGITS(ND), .CODE_W(CW), .DWELL(8), .BLANK(2)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
        .load_ack(load_ack), .code_out(code_out), .digit_en_n(digit_en_n),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Drive one load pulse starting at the current negedge; returns one negedge later.
    task automatic pulse_load(input logic [ND*CW-1:0] val);
        load = 1'b1;
        digits_in = val;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Observation only: counts load_ack pulses up to the next frame_start, then samples each digit's first SHOW cycle.
    task automatic capture_frame(output logic [ND*CW-1:0] codes, output logic [4*ND-1:0] ens,
                                 output int acks, output bit timed_out);
        acks = 0;
        timed_out = 1'b1;
        codes = '0;
        ens = '0;
        for (int i = 0; i < 100; i++) begin
            if (frame_start) begin
                timed_out = 1'b0;
                break;
            end
            if (load_ack) acks++;
            @(negedge clk);
        end
        if (!timed_out) begin
            for (int k = 0; k < ND; k++) begin
                if (k != 0) repeat (10) @(negedge clk);
                codes[k*CW +: CW] = code_out;
                ens[k*4 +: 4] = 4'(digit_en_n);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        logic [3:0] exp_en;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if (digit_en_n !== 4'b1111 || code_out !== 5'd0 || load_ack !== 1'b0 || frame_start !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_hold: en=%b code=%0d ack=%b fs=%b, required en=1111 code=0 ack=0 fs=0",
                         digit_en_n, code_out, load_ack, frame_start);
            end
        end
        rst_n = 1'b1;
        n = 0;
        while (n < 50 && frame_start !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n !== 2) begin
            mismatched++;
            $display("FAIL reset_first_frame_start: cycles=%0d, required 2", n);
        end
        for (int c = 0; c < 18; c++) begin
            exp_en = (c < 8) ? 4'b1110 : (c < 10) ? 4'b1111 : 4'b1101;
            compared++;
            if (digit_en_n !== exp_en) begin
                mismatched++;
                $display("FAIL reset_scan_seq[%0d]: en=%b, required %b", c, digit_en_n, exp_en);
            end
            if (c != 17) @(negedge clk);
        end
    endtask

    task automatic test_first_load();
        logic [ND*CW-1:0] codes, exp;
        logic [4*ND-1:0] ens;
        int acks;
        bit to;
        pulse_load({5'h03, 5'h02, 5'h01, 5'h00});
        sb.push_back({5'h03, 5'h02, 5'h01, 5'h00});
        capture_frame(codes, ens, acks, to);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        compared++;
        if (to) begin mismatched++; $display("FAIL first_load_timeout: frame_start not seen, required within 100 cycles"); end
        compared++;
        if (acks !== 1) begin mismatched++; $display("FAIL first_load_ack: acks=%0d, required 1", acks); end
        compared++;
        if (codes !== exp) begin mismatched++; $display("FAIL first_load_codes: got %h, required %h", codes, exp); end
        compared++;
        if (ens !== 16'b0111_1011_1101_1110) begin
            mismatched++;
            $display("FAIL first_load_enables: got %b, required 0111101111011110", ens);
        end
    endtask

    task automatic test_overwrite();
        logic [ND*CW-1:0] codes, exp;
        logic [4*ND-1:0] ens;
        int acks;
        bit to;
        pulse_load({5'h1f, 5'h0a, 5'h15, 5'h07});
        repeat (3) @(negedge clk);
        pulse_load({5'h11, 5'h04, 5'h1c, 5'h09});
        sb.push_back({5'h11, 5'h04, 5'h1c, 5'h09});
        capture_frame(codes, ens, acks, to);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        compared++;
        if (to) begin mismatched++; $display("FAIL overwrite_timeout: frame_start not seen, required within 100 cycles"); end
        compared++;
        if (acks !== 1) begin mismatched++; $display("FAIL overwrite_ack: acks=%0d, required 1", acks); end
        compared++;
        if (codes !== exp) begin mismatched++; $display("FAIL overwrite_codes: got %h, required %h", codes, exp); end
    endtask

    task automatic test_load_at_commit();
        logic [ND*CW-1:0] codes, exp;
        logic [4*ND-1:0] ens;
        int acks;
        bit to;
        pulse_load({5'h0e, 5'h0d, 5'h0c, 5'h0b});
        sb.push_back({5'h0e, 5'h0d, 5'h0c, 5'h0b});
        repeat (6) @(negedge clk);
        // Now in the last SHOW cycle of digit 3: the next edge is the commit edge
        pulse_load({5'h18, 5'h12, 5'h06, 5'h1e});
        sb.push_back({5'h18, 5'h12, 5'h06, 5'h1e});
        for (int f = 0; f < 3; f++) begin
            capture_frame(codes, ens, acks, to);
            if (f < 2) exp = (sb.size() != 0) ? sb.pop_front() : 'x;
            compared++;
            if (to) begin mismatched++; $display("FAIL coincide_timeout[%0d]: frame_start not seen, required within 100 cycles", f); end
            compared++;
            if (acks !== ((f < 2) ? 1 : 0)) begin
                mismatched++;
                $display("FAIL coincide_ack[%0d]: acks=%0d, required %0d", f, acks, (f < 2) ? 1 : 0);
            end
            compared++;
            if (codes !== exp) begin mismatched++; $display("FAIL coincide_codes[%0d]: got %h, required %h", f, codes, exp); end
        end
    endtask

    task automatic test_async_reset();
        logic [ND*CW-1:0] codes, exp;
        logic [4*ND-1:0] ens;
        int acks, n;
        bit to;
        n = 0;
        while (n < 100 && frame_start !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        compared++;
        if (digit_en_n !== 4'b1011) begin mismatched++; $display("FAIL areset_pre_en: en=%b, required 1011", digit_en_n); end
        pulse_load({5'h13, 5'h17, 5'h19, 5'h1d});
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (digit_en_n !== 4'b1111 || code_out !== 5'd0) begin
            mismatched++;
            $display("FAIL areset_immediate: en=%b code=%0d, required en=1111 code=0", digit_en_n, code_out);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('0);
        capture_frame(codes, ens, acks, to);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        compared++;
        if (to) begin mismatched++; $display("FAIL areset_timeout: frame_start not seen, required within 100 cycles"); end
        compared++;
        if (acks !== 0) begin mismatched++; $display("FAIL areset_ack: acks=%0d, required 0", acks); end
        compared++;
        if (codes !== exp) begin mismatched++; $display("FAIL areset_codes: got %h, required %h", codes, exp); end
        capture_frame(codes, ens, acks, to);
        compared++;
        if (to || acks !== 0 || codes !== exp) begin
            mismatched++;
            $display("FAIL areset_discard: to=%0d acks=%0d codes=%h, required to=0 acks=0 codes=%h", to, acks, codes, exp);
        end
    endtask

    task automatic test_blanking();
        logic [ND*CW-1:0] codes, exp;
        logic [4*ND-1:0] ens;
        logic [3:0] prev_en;
        logic [4:0] prev_code;
        int acks, blank_run, lit_run;
        bit to, blank_full, lit_full;
        pulse_load({5'h1a, 5'h05, 5'h1b, 5'h0f});
        sb.push_back({5'h1a, 5'h05, 5'h1b, 5'h0f});
        capture_frame(codes, ens, acks, to);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        compared++;
        if (to || acks !== 1 || codes !== exp) begin
            mismatched++;
            $display("FAIL blank_setup: to=%0d acks=%0d codes=%h, required to=0 acks=1 codes=%h", to, acks, codes, exp);
        end
        prev_en = digit_en_n;
        prev_code = code_out;
        blank_run = 0;
        lit_run = 0;
        blank_full = 1'b0;
        lit_full = 1'b0;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            compared++;
            if ($countones(~digit_en_n) > 1) begin
                mismatched++;
                $display("FAIL blank_onehot[%0d]: en=%b, required at most one low bit", c, digit_en_n);
            end
            if (digit_en_n !== 4'b1111) begin
                compared++;
                if (code_out !== prev_code) begin
                    mismatched++;
                    $display("FAIL blank_code_stable[%0d]: code=%0d, required %0d", c, code_out, prev_code);
                end
            end
            if (digit_en_n === 4'b1111) begin
                if (prev_en !== 4'b1111) begin
                    if (lit_full) begin
                        compared++;
                        if (lit_run !== 8) begin mismatched++; $display("FAIL blank_lit_len[%0d]: len=%0d, required 8", c, lit_run); end
                    end
                    blank_run = 1;
                    blank_full = 1'b1;
                end else begin
                    blank_run++;
                end
            end else if (prev_en === 4'b1111) begin
                if (blank_full) begin
                    compared++;
                    if (blank_run !== 2) begin mismatched++; $display("FAIL blank_gap[%0d]: gap=%0d, required 2", c, blank_run); end
                end
                lit_run = 1;
                lit_full = 1'b1;
            end else begin
                compared++;
                if (digit_en_n !== prev_en) begin
                    mismatched++;
                    $display("FAIL blank_direct_switch[%0d]: en=%b after %b, required an all-ones gap", c, digit_en_n, prev_en);
                end
                lit_run++;
            end
            prev_en = digit_en_n;
            prev_code = code_out;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_load();
        test_overwrite();
        test_load_at_commit();
        test_async_reset();
        test_blanking();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
